matrix_search: RTL and testbench
================================

Name: matrix_search

Overview:
- Initiator-side companion to the matrix lookup block.
- Given a target value, it raster-scans the matrix through the lookup request/response interface: x fastest, then y.
- Reports the first (y, x) whose stored value equals the target, or not-found.
- Sits between control logic (command/result) and the matrix lookup port; it is the requester, the matrix is the responder.

Parameters:
- MAX_VALUE, 255, largest storable matrix value; NUM_WIDTH = clog2(MAX_VALUE+1).
- NUM_X, 8, matrix columns; X_IDX = clog2(NUM_X).
- NUM_Y, 8, matrix rows; Y_IDX = clog2(NUM_Y).
- MAX_OUTSTANDING, 4, max requests in flight; must be at least the matrix latency to sustain 1 request/cycle. OUT_W = clog2(MAX_OUTSTANDING+1).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- start_i  in  1  command strobe; accepted only in IDLE
- target_i  in  NUM_WIDTH  value to find; sampled with an accepted start_i
- busy_o  out  1  high from the cycle after acceptance until done_o
- done_o  out  1  single-cycle completion pulse
- found_o  out  1  match found; valid from done_o, held until next accepted start
- x_o  out  X_IDX  column of the match; 0 if not found
- y_o  out  Y_IDX  row of the match; 0 if not found
- protocol_err_o  out  1  sticky: response received with zero outstanding
- req_valid_o  out  1  lookup request valid
- req_x_o  out  X_IDX  requested column
- req_y_o  out  Y_IDX  requested row
- rsp_valid_i  in  1  lookup response valid; responses arrive in order
- rsp_x_i  in  X_IDX  column echoed with the response
- rsp_y_i  in  Y_IDX  row echoed with the response
- rsp_value_i  in  NUM_WIDTH  matrix value at (rsp_y_i, rsp_x_i)

Behaviour:
- Reset (rst_i sampled high): state IDLE; all outputs 0; scan counters, outstanding count and target cleared. Reset mid-search aborts immediately, with no done_o.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE: req_valid_o = 0.
  - start_i: latch target; scan = (0,0); found cleared; x_o/y_o = 0; -> ISSUE.
  - start_i in any other state is ignored.
- ISSUE:
  - req_valid_o = (outstanding < MAX_OUTSTANDING); req_x_o/req_y_o = scan counters.
  - Each issued request advances x; when x = NUM_X-1, x wraps to 0 and y increments.
  - Issuing (NUM_Y-1, NUM_X-1) -> DRAIN.
  - A response match -> DRAIN from the next cycle; a request issued in the match cycle still counts as outstanding.
- Outstanding count: +1 on issue, -1 on rsp_valid_i; both in the same cycle leaves it unchanged.
  - It never underflows: rsp_valid_i at count 0 is ignored and sets protocol_err_o.
  - protocol_err_o clears only on reset.
- Match rule: rsp_valid_i && rsp_value_i == target && !found.
  - Capture x_o = rsp_x_i, y_o = rsp_y_i, found = 1.
  - Later responses in that search are not compared, so the result is the first match in raster order.
  - Responses arriving in DRAIN before any match are still compared; a match there is recorded.
- DRAIN: req_valid_o = 0. Move to DONE when outstanding reaches 0, including the cycle where a final response brings it 1 -> 0.
- DONE: done_o = 1 for exactly one cycle, found_o valid; -> IDLE. busy_o = 0 in DONE.
- Latency:
  - First request issues the cycle after start_i.
  - No stall, no match: NUM_X*NUM_Y request cycles, then drain time equal to matrix latency, then 1 DONE cycle.
- Boundaries:
  - NUM_X, NUM_Y powers of two or not; counters compare against NUM_-1 and never run past the end.
  - Target 0 is legal.
  - Target > MAX_VALUE is impossible by width.

Decomposition:
- Shared header/package matrix_pkg: MAX_VALUE/NUM_X/NUM_Y defaults, derived widths (NUM_WIDTH, X_IDX, Y_IDX), state encoding.
- One sub-module: matrix_raster_cnt.
  - Inputs: clear, advance.
  - Outputs: x, y, last (x = NUM_X-1 && y = NUM_Y-1).
- FSM, outstanding counter and compare stay in matrix_search.

Test Plan:
- Setup for all: in-order matrix model, latency 2, value(y,x) = 8*y + x, 8x8, MAX_OUTSTANDING 4.
- Target 0 -> found_o=1, x_o=0, y_o=0. done_o exactly once; no req_valid_o after DRAIN entry; outstanding 0 at DONE.
- Target 63 -> found_o=1, y_o=7, x_o=7. Exactly 64 requests issued, in raster order, with no gaps.
- Matrix with values 42 at (2,5) and (6,1), all others 0; target 42 -> y_o=2, x_o=5 (first in raster order); the second match is ignored.
- Target 200 with no match -> found_o=0, x_o=y_o=0. 64 requests; done_o after the last response; protocol_err_o=0.
- Model latency 6 (> MAX_OUTSTANDING) -> req_valid_o stalls at 4 outstanding, never exceeds 4; correct result for target 63.
- Edge cases:
  - rst_i pulsed mid-ISSUE -> all outputs 0 next cycle, no done_o.
  - Stray rsp_valid_i in IDLE -> protocol_err_o=1, sticky.
  - start_i while busy -> ignored.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared defaults, derived widths and FSM encoding for the matrix search block.
package matrix_pkg;

  localparam int DEF_MAX_VALUE       = 255;
  localparam int DEF_NUM_X           = 8;
  localparam int DEF_NUM_Y           = 8;
  localparam int DEF_MAX_OUTSTANDING = 4;

  localparam int DEF_NUM_WIDTH = $clog2(DEF_MAX_VALUE + 1);
  localparam int DEF_X_IDX     = $clog2(DEF_NUM_X);
  localparam int DEF_Y_IDX     = $clog2(DEF_NUM_Y);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/matrix_raster_cnt.sv
// Raster-order (x fastest, then y) scan position generator for the matrix search.
module matrix_raster_cnt
  import matrix_pkg::*;
#(
  parameter  int NUM_X = DEF_NUM_X,
  parameter  int NUM_Y = DEF_NUM_Y,
  localparam int X_IDX = $clog2(NUM_X),
  localparam int Y_IDX = $clog2(NUM_Y)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear,
  input  logic             advance,
  output logic [X_IDX-1:0] x,
  output logic [Y_IDX-1:0] y,
  output logic             last
);

  localparam logic [X_IDX-1:0] X_LAST = X_IDX'(NUM_X - 1);
  localparam logic [Y_IDX-1:0] Y_LAST = Y_IDX'(NUM_Y - 1);

  // Compare against the real end coordinates so non-power-of-two sizes stop correctly.
  assign last = (x == X_LAST) && (y == Y_LAST);

  // Scan position: cleared for a new search, stepped once per issued request,
  // parked on the final cell so it never runs past the end of the matrix.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst_i || clear) begin
      x <= '0;
      y <= '0;
    end else if (advance && !last) begin
      if (x == X_LAST) begin
        x <= '0;
        y <= y + Y_IDX'(1);
      end else begin
        x <= x + X_IDX'(1);
      end
    end
  end

endmodule

// File: rtl/matrix_search.sv
// Requester that raster-scans the matrix lookup port for the first cell equal to a target.
module matrix_search
  import matrix_pkg::*;
#(
  parameter  int MAX_VALUE       = DEF_MAX_VALUE,
  parameter  int NUM_X           = DEF_NUM_X,
  parameter  int NUM_Y           = DEF_NUM_Y,
  parameter  int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
  localparam int NUM_WIDTH       = $clog2(MAX_VALUE + 1),
  localparam int X_IDX           = $clog2(NUM_X),
  localparam int Y_IDX           = $clog2(NUM_Y),
  localparam int OUT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [NUM_WIDTH-1:0] target_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 found_o,
  output logic [X_IDX-1:0]     x_o,
  output logic [Y_IDX-1:0]     y_o,
  output logic                 protocol_err_o,
  output logic                 req_valid_o,
  output logic [X_IDX-1:0]     req_x_o,
  output logic [Y_IDX-1:0]     req_y_o,
  input  logic                 rsp_valid_i,
  input  logic [X_IDX-1:0]     rsp_x_i,
  input  logic [Y_IDX-1:0]     rsp_y_i,
  input  logic [NUM_WIDTH-1:0] rsp_value_i
);

  localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUTSTANDING);

  state_t               state_q, state_d;
  logic [NUM_WIDTH-1:0] target_q;
  logic [OUT_W-1:0]     out_q, out_d;
  logic                 found_q;
  logic [X_IDX-1:0]     x_q;
  logic [Y_IDX-1:0]     y_q;
  logic                 perr_q;

  logic                 accept;
  logic                 issue;
  logic                 rsp_ok;
  logic                 match;
  logic                 scan_last;
  logic [X_IDX-1:0]     scan_x;
  logic [Y_IDX-1:0]     scan_y;

  // A response with nothing in flight is a protocol error and must not touch the count.
  assign accept = (state_q == ST_IDLE) && start_i;
  assign issue  = (state_q == ST_ISSUE) && (out_q < OUT_MAX);
  assign rsp_ok = rsp_valid_i && (out_q != '0);
  assign match  = rsp_ok && (rsp_value_i == target_q) && !found_q;

  matrix_raster_cnt #(
    .NUM_X (NUM_X),
    .NUM_Y (NUM_Y)
  ) u_raster (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear   (accept),
    .advance (issue),
    .x       (scan_x),
    .y       (scan_y),
    .last    (scan_last)
  );

  // Outstanding request count: +1 per issue, -1 per valid response, unchanged when both.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    out_d = out_q;
    if (issue && !rsp_ok) begin
      out_d = out_q + OUT_W'(1);
    end else if (!issue && rsp_ok) begin
      out_d = out_q - OUT_W'(1);
    end
  end

  // Next-state logic for IDLE -> ISSUE -> DRAIN -> DONE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start_i) state_d = ST_ISSUE;
      ST_ISSUE: if ((issue && scan_last) || match) state_d = ST_DRAIN;
      ST_DRAIN: if (out_d == '0) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State, counters, latched target and result capture; reset aborts any search at once.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      out_q    <= '0;
      target_q <= '0;
      found_q  <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      perr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      if (accept) begin
        target_q <= target_i;
        found_q  <= 1'b0;
        x_q      <= '0;
        y_q      <= '0;
      end else if (match) begin
        found_q <= 1'b1;
        x_q     <= rsp_x_i;
        y_q     <= rsp_y_i;
      end
      if (rsp_valid_i && (out_q == '0)) begin
        perr_q <= 1'b1;
      end
    end
  end

  assign busy_o         = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
  assign done_o         = (state_q == ST_DONE);
  assign found_o        = found_q;
  assign x_o            = x_q;
  assign y_o            = y_q;
  assign protocol_err_o = perr_q;
  assign req_valid_o    = issue;
  assign req_x_o        = scan_x;
  assign req_y_o        = scan_y;

endmodule

// File: tb/tb_matrix_search.sv
// Scoreboard bench for matrix_search: in-order matrix model, request/result monitor.
`timescale 1ns/1ps
module tb_matrix_search;
  import matrix_pkg::*;

  localparam int NW   = DEF_NUM_WIDTH;
  localparam int XW   = DEF_X_IDX;
  localparam int YW   = DEF_Y_IDX;
  localparam int MAXO = DEF_MAX_OUTSTANDING;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          start_i;
  logic [NW-1:0] target_i;
  logic          busy_o, done_o, found_o, protocol_err_o;
  logic [XW-1:0] x_o, req_x_o, rsp_x_i;
  logic [YW-1:0] y_o, req_y_o, rsp_y_i;
  logic          req_valid_o, rsp_valid_i;
  logic [NW-1:0] rsp_value_i;

  always #5 clk = ~clk;

  matrix_search #(
    .MAX_VALUE       (DEF_MAX_VALUE),
    .NUM_X           (DEF_NUM_X),
    .NUM_Y           (DEF_NUM_Y),
    .MAX_OUTSTANDING (DEF_MAX_OUTSTANDING)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .start_i        (start_i),
    .target_i       (target_i),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .found_o        (found_o),
    .x_o            (x_o),
    .y_o            (y_o),
    .protocol_err_o (protocol_err_o),
    .req_valid_o    (req_valid_o),
    .req_x_o        (req_x_o),
    .req_y_o        (req_y_o),
    .rsp_valid_i    (rsp_valid_i),
    .rsp_x_i        (rsp_x_i),
    .rsp_y_i        (rsp_y_i),
    .rsp_value_i    (rsp_value_i)
  );

  typedef struct {
    bit found;
    int x;
    int y;
    int nreq;
    int max_out;
    bit nogap;
  } exp_t;

  typedef struct {
    int x;
    int y;
    int due;
  } pend_t;

  exp_t  exp_q[$];
  pend_t pend[$];
  int    mem[8][8];
  int    lat = 2;
  int    cyc = 0;
  int    done_cnt = 0;
  int    stray_req = 0;
  int    stray_done = 0;
  int    timeouts = 0;
  bit    sim_done = 1'b0;
  int    n_checks = 0;
  int    n_fail = 0;

  // Monitor state
  bit prev_rst, prev_start, prev_stray, exp_perr, over, order_ok, gap;
  int mon_out, old_out, nreq, ex, ey, start_cyc, first_req, last_req, last_rsp, max_out;
  exp_t e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // In-order matrix model with configurable latency; flushes on reset.
  initial begin
    pend_t p;
    int v;
    rsp_valid_i = 1'b0; rsp_x_i = '0; rsp_y_i = '0; rsp_value_i = '0;
    forever begin
      @(posedge clk); #2;
      rsp_valid_i = 1'b0;
      if (rst_i === 1'b1) begin
        pend.delete();
        continue;
      end
      if (stray_req > stray_done) begin
        stray_done++;
        rsp_valid_i = 1'b1; rsp_x_i = '0; rsp_y_i = '0; rsp_value_i = '0;
      end else if (pend.size() > 0 && pend[0].due <= cyc) begin
        p = pend.pop_front();
        v = mem[p.y][p.x];
        rsp_valid_i = 1'b1;
        rsp_x_i = p.x[XW-1:0];
        rsp_y_i = p.y[YW-1:0];
        rsp_value_i = v[NW-1:0];
      end
      if (req_valid_o === 1'b1) begin
        p.x = int'(req_x_o);
        p.y = int'(req_y_o);
        p.due = cyc + lat;
        pend.push_back(p);
      end
    end
  end

  // Monitor: tracks requests/outstanding, pops the scoreboard on done_o, owns all checks.
  initial begin
    prev_rst = 0; prev_start = 0; prev_stray = 0; exp_perr = 0; mon_out = 0;
    nreq = 0; ex = 0; ey = 0; start_cyc = 0; first_req = -1; last_req = -1;
    last_rsp = -1; max_out = 0; over = 0; order_ok = 1; gap = 0;
    forever begin
      @(negedge clk);
      if (sim_done) break;
      if (prev_rst) begin
        check("rst_busy", 64'(busy_o), 0);
        check("rst_done", 64'(done_o), 0);
        check("rst_found", 64'(found_o), 0);
        check("rst_x", 64'(x_o), 0);
        check("rst_y", 64'(y_o), 0);
        check("rst_perr", 64'(protocol_err_o), 0);
        check("rst_req_valid", 64'(req_valid_o), 0);
      end
      if (prev_start) check("busy_after_start", 64'(busy_o), 1);
      if (prev_stray) check("perr_after_stray", 64'(protocol_err_o), 1);
      prev_start = 0;
      prev_stray = 0;
      if (rst_i) begin
        prev_rst = 1; mon_out = 0; exp_perr = 0;
        continue;
      end
      prev_rst = 0;
      if (start_i && !busy_o && !done_o) begin
        prev_start = 1; nreq = 0; ex = 0; ey = 0; start_cyc = cyc; first_req = -1;
        last_req = -1; last_rsp = -1; max_out = 0; over = 0; order_ok = 1; gap = 0;
      end
      old_out = mon_out;
      if (rsp_valid_i) begin
        if (old_out == 0) begin
          exp_perr = 1; prev_stray = 1;
        end else begin
          mon_out--; last_rsp = cyc;
        end
      end
      if (req_valid_o) begin
        if (old_out >= MAXO) over = 1;
        if (int'(req_x_o) != ex || int'(req_y_o) != ey) order_ok = 0;
        if (ex == 7) begin ex = 0; ey++; end else ex++;
        if (first_req < 0) first_req = cyc;
        if (last_req >= 0 && cyc != last_req + 1) gap = 1;
        last_req = cyc;
        nreq++;
        mon_out++;
      end
      if (mon_out > max_out) max_out = mon_out;
      if (done_o) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("found", 64'(found_o), 64'(e.found));
          check("x", 64'(x_o), 64'(e.x));
          check("y", 64'(y_o), 64'(e.y));
          check("busy_in_done", 64'(busy_o), 0);
          check("outstanding_at_done", 64'(mon_out), 0);
          check("request_count", 64'(nreq), 64'(e.nreq));
          check("raster_order", 64'(order_ok), 1);
          check("first_req_latency", 64'(first_req), 64'(start_cyc + 1));
          check("max_outstanding", 64'(max_out), 64'(e.max_out));
          check("never_over_limit", 64'(over), 0);
          check("done_after_last_rsp", 64'(cyc), 64'(last_rsp + 1));
          if (e.nogap) check("no_request_gaps", 64'(gap), 0);
          check("perr_at_done", 64'(protocol_err_o), 64'(exp_perr));
        end
      end
    end
    check("scoreboard_empty", 64'(exp_q.size()), 0);
    check("search_timeouts", 64'(timeouts), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  task automatic fill_linear();
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++)
        mem[y][x] = 8 * y + x;
  endtask

  task automatic do_search(input int tgt, input bit ef, input int ex_x, input int ex_y,
                           input int enreq, input int emax, input bit nogap, input bit poke);
    exp_t ee;
    int   base;
    bit   seen;
    ee.found = ef; ee.x = ex_x; ee.y = ex_y; ee.nreq = enreq; ee.max_out = emax; ee.nogap = nogap;
    exp_q.push_back(ee);
    base = done_cnt;
    @(posedge clk); #1;
    start_i = 1'b1; target_i = tgt[NW-1:0];
    @(posedge clk); #1;
    start_i = 1'b0;
    if (poke) begin
      repeat (10) @(posedge clk);
      #1 start_i = 1'b1; target_i = '0;
      @(posedge clk); #1 start_i = 1'b0;
    end
    seen = 0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(posedge clk);
      if (done_cnt != base) seen = 1;
    end
    if (!seen) timeouts++;
    repeat (2) @(posedge clk);
  endtask

  // Directed stimulus with hand-computed expectations (value(y,x) = 8*y + x unless noted).
  initial begin
    rst_i = 1'b1; start_i = 1'b0; target_i = '0;
    fill_linear();
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    repeat (2) @(posedge clk);

    // Target 0: match on first response; requests (0,0),(0,1),(0,2) only.
    do_search(0, 1, 0, 0, 3, 2, 1, 0);
    // Target 63: last cell, match lands in DRAIN; start_i poked while busy.
    do_search(63, 1, 7, 7, 64, 2, 1, 1);
    // Target 200: no match anywhere.
    do_search(200, 0, 0, 0, 64, 2, 1, 0);
    // Two cells hold 42; first in raster order is (y=2,x=5), index 21 -> 24 requests.
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++)
        mem[y][x] = 0;
    mem[2][5] = 42;
    mem[6][1] = 42;
    do_search(42, 1, 5, 2, 24, 2, 1, 0);
    // Latency 6 exceeds the in-flight limit: issue stalls at 4.
    fill_linear();
    lat = 6;
    do_search(63, 1, 7, 7, 64, 4, 0, 0);
    lat = 2;

    // Reset pulsed mid-ISSUE: outputs clear, no done_o follows.
    @(posedge clk); #1 start_i = 1'b1; target_i = 8'd63;
    @(posedge clk); #1 start_i = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_i = 1'b1;
    @(posedge clk); #1 rst_i = 1'b0;
    repeat (20) @(posedge clk);

    // Stray response in IDLE sets the sticky error; next search keeps it set.
    #1 stray_req++;
    repeat (4) @(posedge clk);
    do_search(9, 1, 1, 1, 12, 2, 1, 0);

    // Reset clears the sticky error.
    #1 rst_i = 1'b1;
    @(posedge clk); #1 rst_i = 1'b0;
    repeat (4) @(posedge clk);
    sim_done = 1'b1;
  end

endmodule
